run_control: RTL and testbench



---
 rtl/run_control_pkg.sv | 20 ++
 rtl/run_control_rate_divider.sv | 22 ++
 rtl/run_control.sv | 133 +++++++++++++
 tb/tb_run_control.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/run_control_pkg.sv
// Shared constants for the run-control unit: mode codes, FSM encoding and
// default widths.
package run_control_pkg;

  localparam int CNT_WIDTH_DEF = 16;
  localparam int DIV_WIDTH_DEF = 26;
  localparam int N_WIDTH_DEF   = 16;
  localparam int PC_WIDTH_DEF  = 32;

  localparam logic [1:0] MODE_STEP   = 2'b00;
  localparam logic [1:0] MODE_FREE   = 2'b01;
  localparam logic [1:0] MODE_RUN_N  = 2'b10;
  localparam logic [1:0] MODE_RUN_BP = 2'b11;

  typedef enum logic {
    HALT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/run_control_rate_divider.sv
// Programmable rate divider: tick fires when the count reaches limit, giving
// a period of limit+1 clocks; held at zero while clear is asserted.
module rate_divider #(
  parameter int DIV_WIDTH = 26
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [DIV_WIDTH-1:0] limit,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] count;

  assign tick = (count == limit);

  always_ff @(posedge clock) begin
    if (reset || clear || tick) count <= '0;
    else                        count <= count + 1'b1;
  end

endmodule

// File: rtl/run_control.sv
// Run-control unit: turns the step button and mode switches into a single
// clock-enable strobe for the teaching computer, plus cycle bookkeeping.
module run_control
  import run_control_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int DIV_WIDTH = DIV_WIDTH_DEF,
  parameter int N_WIDTH   = N_WIDTH_DEF,
  parameter int PC_WIDTH  = PC_WIDTH_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [1:0]           mode,
  input  logic                 step_btn,
  input  logic                 clear_count,
  input  logic [DIV_WIDTH-1:0] div_value,
  input  logic [N_WIDTH-1:0]   run_count,
  input  logic                 bp_enable,
  input  logic [PC_WIDTH-1:0]  bp_addr,
  input  logic [PC_WIDTH-1:0]  pc,
  output logic                 cpu_enable,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic                 first_cycle,
  output logic                 halted,
  output logic                 bp_hit
);

  state_t               state, state_next;
  logic                 step_prev, step_edge;
  logic [1:0]           run_mode;
  logic [N_WIDTH-1:0]   remaining, remaining_next;
  logic                 enable_next, bp_hit_next;
  logic                 div_clear, tick;
  logic [CNT_WIDTH-1:0] count_next;

  assign step_edge = step_btn & ~step_prev;

  // Divider only counts while staying in RUN, so every run starts its period
  // from zero.
  assign div_clear = (state != RUN) || (state_next != RUN);

  rate_divider #(.DIV_WIDTH(DIV_WIDTH)) u_div (
    .clock (clock),
    .reset (reset),
    .clear (div_clear),
    .limit (div_value),
    .tick  (tick)
  );

  always_comb begin
    state_next     = state;
    enable_next    = 1'b0;
    remaining_next = remaining;
    bp_hit_next    = bp_hit;
    case (state)
      HALT: begin
        if (step_edge) begin
          case (mode)
            MODE_STEP: enable_next = 1'b1;
            MODE_FREE: begin
              enable_next = 1'b1;
              state_next  = RUN;
            end
            MODE_RUN_N: begin
              if (run_count != '0) begin
                enable_next    = 1'b1;
                remaining_next = run_count - 1'b1;
                // A count of one is finished by the launch enable itself.
                if (run_count != N_WIDTH'(1)) state_next = RUN;
              end
            end
            MODE_RUN_BP: begin
              enable_next = 1'b1;
              state_next  = RUN;
              bp_hit_next = 1'b0;
            end
            default: ;
          endcase
        end
      end
      RUN: begin
        if ((mode != run_mode) || step_edge) begin
          state_next = HALT;
        end else if (tick) begin
          if ((mode == MODE_RUN_BP) && bp_enable && (pc == bp_addr)) begin
            bp_hit_next = 1'b1;
            state_next  = HALT;
          end else begin
            enable_next = 1'b1;
            if (mode == MODE_RUN_N) begin
              remaining_next = remaining - 1'b1;
              if (remaining == N_WIDTH'(1)) state_next = HALT;
            end
          end
        end
      end
      default: state_next = HALT;
    endcase
    if (state_next == HALT) remaining_next = '0;
  end

  always_comb begin
    count_next = cycle_count;
    if (clear_count)     count_next = '0;
    else if (cpu_enable) count_next = cycle_count + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= HALT;
      step_prev   <= 1'b0;
      run_mode    <= MODE_STEP;
      remaining   <= '0;
      cpu_enable  <= 1'b0;
      cycle_count <= '0;
      first_cycle <= 1'b1;
      halted      <= 1'b1;
      bp_hit      <= 1'b0;
    end else begin
      state       <= state_next;
      step_prev   <= step_btn;
      // Mode is latched while halted; any difference seen in RUN aborts.
      if (state == HALT) run_mode <= mode;
      remaining   <= remaining_next;
      cpu_enable  <= enable_next;
      cycle_count <= count_next;
      first_cycle <= (count_next == '0);
      halted      <= (state_next == HALT);
      bp_hit      <= bp_hit_next;
    end
  end

endmodule

// File: tb/tb_run_control.sv
// Randomized scenario bench for run_control; expected enable times are derived
// from start cycle, enable period and stop cycle.
module tb_run_control;
  import run_control_pkg::*;

  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    mode = MODE_STEP;
  logic          step_btn = 1'b0;
  logic          clear_count = 1'b0;
  logic [25:0]   div_value = '0;
  logic [15:0]   run_count = '0;
  logic          bp_enable = 1'b0;
  logic [31:0]   bp_addr = '0;
  logic [31:0]   pc;
  logic          cpu_enable;
  logic [CW-1:0] cycle_count;
  logic          first_cycle, halted, bp_hit;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          n_en = 0;
  logic [31:0] pc_base = '0;
  int          en_q[$];
  logic [31:0] pc_q[$];

  run_control #(.CNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .mode(mode), .step_btn(step_btn),
    .clear_count(clear_count), .div_value(div_value), .run_count(run_count),
    .bp_enable(bp_enable), .bp_addr(bp_addr), .pc(pc),
    .cpu_enable(cpu_enable), .cycle_count(cycle_count),
    .first_cycle(first_cycle), .halted(halted), .bp_hit(bp_hit)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Computer model: PC advances by 4 for every enable it receives.
  assign pc = pc_base + 32'(4 * n_en);

  always @(negedge clock) begin
    if (cpu_enable) begin
      en_q.push_back(cyc);
      pc_q.push_back(pc);
      n_en++;
    end
  end

  task automatic nstep();
    @(negedge clock); #1;
  endtask

  task automatic pulse_step(output int e);
    nstep(); step_btn = 1'b1;
    nstep(); step_btn = 1'b0;
    e = cyc;
  endtask

  task automatic do_reset();
    reset = 1'b1; step_btn = 1'b0; clear_count = 1'b0;
    nstep(); nstep();
    reset = 1'b0;
    nstep();
    en_q.delete(); pc_q.delete();
  endtask

  // Number of enables a run starting at s with period p issues before cycle t.
  function automatic int model_count(int s, int p, int t, int nmax);
    int c = 0;
    while (c < nmax && s + c * p < t) c++;
    return c;
  endfunction

  task automatic test_reset();
    reset = 1'b1; nstep(); nstep(); reset = 1'b0; nstep();
    tests++; if (cpu_enable !== 1'b0) begin fails++; $display("FAIL reset_cpu_enable: got %b want 0", cpu_enable); end
    tests++; if (cycle_count !== '0) begin fails++; $display("FAIL reset_cycle_count: got %0d want 0", cycle_count); end
    tests++; if (first_cycle !== 1'b1) begin fails++; $display("FAIL reset_first_cycle: got %b want 1", first_cycle); end
    tests++; if (halted !== 1'b1) begin fails++; $display("FAIL reset_halted: got %b want 1", halted); end
    tests++; if (bp_hit !== 1'b0) begin fails++; $display("FAIL reset_bp_hit: got %b want 0", bp_hit); end
  endtask

  task automatic test_step();
    int e[3];
    do_reset(); mode = MODE_STEP;
    for (int i = 0; i < 3; i++) begin
      pulse_step(e[i]);
      if (i == 0) begin
        tests++; if (first_cycle !== 1'b1) begin fails++; $display("FAIL step_first_cycle_hi: got %b want 1", first_cycle); end
        nstep();
        tests++; if (first_cycle !== 1'b0) begin fails++; $display("FAIL step_first_cycle_lo: got %b want 0", first_cycle); end
      end
      repeat ($urandom_range(1, 4)) nstep();
    end
    repeat (3) nstep();
    tests++; if (en_q.size() != 3) begin fails++; $display("FAIL step_count: got %0d want 3", en_q.size()); end
    for (int k = 0; k < 3 && k < en_q.size(); k++) begin
      tests++; if (en_q[k] != e[k]) begin fails++; $display("FAIL step_time[%0d]: got %0d want %0d", k, en_q[k], e[k]); end
    end
    tests++; if (cycle_count !== CW'(3)) begin fails++; $display("FAIL step_cycle_count: got %0d want 3", cycle_count); end
    tests++; if (halted !== 1'b1) begin fails++; $display("FAIL step_halted: got %b want 1", halted); end
  endtask

  task automatic test_free(input int div);
    int s, t, p, n;
    do_reset(); mode = MODE_FREE; div_value = 26'(div); p = div + 1;
    pulse_step(s);
    repeat ($urandom_range(3 * p, 5 * p)) nstep();
    pulse_step(t);
    tests++; if (halted !== 1'b1) begin fails++; $display("FAIL free_halted: got %b want 1", halted); end
    repeat (p + 3) nstep();
    n = model_count(s, p, t, 1000);
    tests++; if (en_q.size() != n) begin fails++; $display("FAIL free_count div=%0d: got %0d want %0d", div, en_q.size(), n); end
    for (int k = 0; k < n && k < en_q.size(); k++) begin
      tests++; if (en_q[k] != s + k * p) begin fails++; $display("FAIL free_time[%0d]: got %0d want %0d", k, en_q[k], s + k * p); end
    end
  endtask

  task automatic test_run_n(input int cnt, input int div);
    int s, p, n;
    en_q.delete(); mode = MODE_RUN_N; run_count = 16'(cnt);
    div_value = 26'(div); p = div + 1;
    pulse_step(s);
    repeat (cnt * p + 4) nstep();
    n = model_count(s, p, 1 << 30, cnt);
    tests++; if (en_q.size() != n) begin fails++; $display("FAIL run_n_count n=%0d div=%0d: got %0d want %0d", cnt, div, en_q.size(), n); end
    for (int k = 0; k < n && k < en_q.size(); k++) begin
      tests++; if (en_q[k] != s + k * p) begin fails++; $display("FAIL run_n_time[%0d]: got %0d want %0d", k, en_q[k], s + k * p); end
    end
    tests++; if (halted !== 1'b1) begin fails++; $display("FAIL run_n_halted: got %b want 1", halted); end
  endtask

  task automatic test_run_bp();
    int s, t, p, n;
    do_reset(); mode = MODE_RUN_BP; bp_enable = 1'b1; bp_addr = 32'h10;
    p = $urandom_range(2, 5); div_value = 26'(p - 1);
    pc_base = 32'(0) - 32'(4 * n_en);
    pulse_step(s);
    repeat (5 * p + 3) nstep();
    tests++; if (en_q.size() != 4) begin fails++; $display("FAIL bp_count: got %0d want 4", en_q.size()); end
    for (int k = 0; k < 4 && k < en_q.size(); k++) begin
      tests++; if (en_q[k] != s + k * p || pc_q[k] !== 32'(4 * k)) begin
        fails++; $display("FAIL bp_enable[%0d]: got cyc %0d pc %0h want cyc %0d pc %0h", k, en_q[k], pc_q[k], s + k * p, 4 * k);
      end
    end
    tests++; if (bp_hit !== 1'b1 || halted !== 1'b1 || pc !== 32'h10) begin
      fails++; $display("FAIL bp_stop: got hit %b halted %b pc %0h want 1 1 10", bp_hit, halted, pc);
    end
    en_q.delete(); pc_q.delete();
    pulse_step(s);
    tests++; if (bp_hit !== 1'b0) begin fails++; $display("FAIL bp_hit_clear: got %b want 0", bp_hit); end
    repeat (3 * p) nstep();
    pulse_step(t);
    repeat (p + 2) nstep();
    n = model_count(s, p, t, 1000);
    tests++; if (en_q.size() != n) begin fails++; $display("FAIL bp_restart_count: got %0d want %0d", en_q.size(), n); end
    for (int k = 0; k < n && k < en_q.size(); k++) begin
      tests++; if (en_q[k] != s + k * p || pc_q[k] !== 32'(16 + 4 * k)) begin
        fails++; $display("FAIL bp_restart[%0d]: got cyc %0d pc %0h want cyc %0d pc %0h", k, en_q[k], pc_q[k], s + k * p, 16 + 4 * k);
      end
    end
    bp_enable = 1'b0;
  endtask

  task automatic test_wrap();
    int s, ec;
    do_reset(); mode = MODE_RUN_N; run_count = 16'd17; div_value = '0;
    pulse_step(s);
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) nstep();
      ec = ((k < 17) ? k : 17) % (1 << CW);
      tests++; if (cycle_count !== CW'(ec) || first_cycle !== (ec == 0)) begin
        fails++; $display("FAIL wrap k=%0d: got count %0d fc %b want %0d %b", k, cycle_count, first_cycle, ec, ec == 0);
      end
    end
  endtask

  task automatic test_clear();
    int s;
    do_reset(); mode = MODE_FREE; div_value = '0;
    pulse_step(s);
    repeat (3) nstep();
    clear_count = 1'b1; nstep(); clear_count = 1'b0;
    tests++; if (cycle_count !== '0) begin fails++; $display("FAIL clear_coincident: got %0d want 0", cycle_count); end
    nstep();
    tests++; if (cycle_count !== CW'(1)) begin fails++; $display("FAIL clear_resume: got %0d want 1", cycle_count); end
    pulse_step(s);
  endtask

  task automatic test_mode_abort();
    int s, t, n;
    do_reset(); mode = MODE_FREE; div_value = 26'd3;
    pulse_step(s);
    repeat ($urandom_range(5, 9)) nstep();
    mode = MODE_RUN_N; nstep(); t = cyc;
    tests++; if (halted !== 1'b1) begin fails++; $display("FAIL abort_halted: got %b want 1", halted); end
    repeat (10) nstep();
    n = model_count(s, 4, t, 1000);
    tests++; if (en_q.size() != n) begin fails++; $display("FAIL abort_count: got %0d want %0d", en_q.size(), n); end
  endtask

  task automatic test_reset_midrun();
    int s, w;
    do_reset(); mode = MODE_RUN_N; run_count = 16'd10; div_value = 26'($urandom_range(1, 3));
    pulse_step(s);
    w = 0;
    while (en_q.size() < 7 && w < 200) begin nstep(); w++; end
    tests++; if (en_q.size() != 7) begin fails++; $display("FAIL midrun_wait: got %0d enables want 7", en_q.size()); end
    reset = 1'b1; step_btn = 1'b1;
    nstep();
    reset = 1'b0; step_btn = 1'b0;
    tests++; if (cpu_enable !== 1'b0 || cycle_count !== '0 || first_cycle !== 1'b1 || halted !== 1'b1 || bp_hit !== 1'b0) begin
      fails++; $display("FAIL midrun_reset: got en %b cnt %0d fc %b halt %b hit %b want 0 0 1 1 0",
                        cpu_enable, cycle_count, first_cycle, halted, bp_hit);
    end
    repeat (40) nstep();
    tests++; if (en_q.size() != 7) begin fails++; $display("FAIL midrun_no_more: got %0d enables want 7", en_q.size()); end
  endtask

  initial begin
    test_reset();
    test_step();
    test_free(4);
    test_free($urandom_range(0, 6));
    test_run_n(5, 0);
    test_run_n(0, $urandom_range(0, 3));
    test_run_n(1, $urandom_range(0, 3));
    for (int i = 0; i < 3; i++) test_run_n($urandom_range(2, 6), $urandom_range(0, 3));
    test_run_bp();
    test_wrap();
    test_clear();
    test_mode_abort();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
